pwm_multi_channel: RTL
======================

// Module: pwm_multi_channel
// PURPOSE
//  - N-channel PWM generator for RGB/LED-strip drive (one channel per colour or segment).
//  - Shared period counter with a clock prescaler; per-channel duty is double-buffered and
//    takes effect only at a period boundary, so updates never produce a glitched output period.
//  - Optional fade mode: active duty ramps toward the loaded target by STEP once per period.
//  - Sits between the register/host logic (supplies duty words) and the LED driver pins.
// PARAMETERS
//  CHANNELS  3    number of PWM outputs
//  WIDTH     8    duty/counter width; period = 2**WIDTH ticks
//  PRESCALE  1    clk12MHz cycles per counter tick (>=1); 1 = count every clock
//  STEP      1    fade increment/decrement per period (1..2**WIDTH-1)
// PORTS
//  clk12MHz     in   1               system clock, all logic on rising edge
//  resetn       in   1               synchronous reset, active low
//  duty_in      in   CHANNELS*WIDTH  packed duty words, channel i at [i*WIDTH +: WIDTH]
//  duty_load    in   1               1-cycle strobe: capture duty_in into target regs
//  fade_en      in   1               0 = jump to target at boundary; 1 = ramp by STEP
//  pwm_out      out  CHANNELS        registered PWM outputs, active high
//  period_start out  1               1-cycle pulse in the cycle the counter wraps to 0
//  busy         out  1               1 while any active duty != its target
// BEHAVIOUR
//  - Reset (resetn=0 at clock edge): prescaler=0, timer=0, target[]=0, active[]=0,
//    pwm_out=0, period_start=0, busy=0. Reset mid-period aborts the period immediately.
//  - Prescaler: counts 0..PRESCALE-1; tick asserted when it equals PRESCALE-1, then wraps to 0.
//    PRESCALE=1 -> tick every cycle.
//  - Timer: WIDTH bits, increments on tick, wraps 2**WIDTH-1 -> 0 (natural overflow).
//  - Boundary = tick && timer==2**WIDTH-1. period_start is registered: high for exactly one
//    clock, coincident with the first cycle timer==0.
//  - Output: pwm_out[i] <= (timer < active[i]), registered, 1 clock latency from timer.
//    duty 0 -> constantly low; duty 2**WIDTH-1 -> high 2**WIDTH-1 of 2**WIDTH ticks.
//  - duty_load: target[] <= duty_in on the strobe cycle; any number of loads per period,
//    last one before the boundary wins. duty_load is ignored while resetn=0.
//  - At boundary, per channel:
//      fade_en=0: active <= target.
//      fade_en=1: if active<target: active <= min(active+STEP, target);
//                 if active>target: active <= max(active-STEP, target); else hold.
//      Arithmetic done in WIDTH+1 bits; never wraps, saturates exactly at target.
//  - Simultaneous duty_load and boundary: boundary update uses the OLD target; new target
//    is applied at the next boundary.
//  - fade_en sampled only at the boundary; toggling mid-period has no effect until then.
//  - busy: registered, = OR over channels of (active != target), recomputed every cycle.
//  - No state machine beyond the counters; per-channel logic identical and independent.
// STRUCTURE
//  - Shared package pwm_pkg: localparam helpers (MAX_DUTY = 2**WIDTH-1), function
//    fade_next(active, target, step) returning saturated next duty.
//  - Sub-module pwm_channel: holds target/active regs, compare and fade update for one
//    channel; instantiated CHANNELS times by generate. Top holds prescaler, timer, busy OR.
// TESTING
//  - Reset: hold resetn=0 5 cycles with duty_in=all 0xFF -> pwm_out=0, busy=0, timer=0.
//  - Static duty, PRESCALE=1: load {0x00,0x80,0xFF} -> from 2nd period ch0 never high,
//    ch1 high 128/256 clocks, ch2 high 255/256; period_start every 256 clocks.
//  - Double buffer: load 0x40 mid-period -> current period keeps old duty, new high time
//    64 clocks from next period; load on boundary cycle -> applied one period later.
//  - Fade: fade_en=1, STEP=16, active 0x00, load 0xFF -> active 0x10,0x20..0xF0,0xFF over
//    16 periods (last step saturates), busy drops the cycle after reaching 0xFF; then load
//    0x08 -> ramps down 0xEF..0x0F,0x08.
//  - PRESCALE=4: duty 0x80 -> high 512 clocks of 1024; period_start every 1024 clocks.
//  - Reset mid-fade: assert resetn=0 during ramp -> all outputs 0 next edge, restart clean.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared helpers for the multi-channel PWM generator
package pwm_pkg;

  // Widest duty word the helpers support; channels zero-extend into this.
  localparam int DUTY_W_MAX = 16;

  typedef logic [DUTY_W_MAX-1:0] duty_t;

  // Largest duty value for a given counter width (2**width - 1).
  function automatic duty_t max_duty(input int width);
    return duty_t'((32'd1 << width) - 32'd1);
  endfunction

  // One fade step toward target, saturating exactly at target.
  // Done one bit wider than the duty so neither direction can wrap.
  function automatic duty_t fade_next(input duty_t active, input duty_t target, input duty_t step);
    logic [DUTY_W_MAX:0] a;
    logic [DUTY_W_MAX:0] t;
    logic [DUTY_W_MAX:0] s;
    logic [DUTY_W_MAX:0] r;
    a = {1'b0, active};
    t = {1'b0, target};
    s = {1'b0, step};
    r = a;
    if (a < t) begin
      r = ((a + s) > t) ? t : (a + s);
    end else if (a > t) begin
      r = (a < (t + s)) ? t : (a - s);
    end
    return r[DUTY_W_MAX-1:0];
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: double-buffered duty, fade, compare
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk12MHz,
  input  logic             resetn,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_load,
  input  logic             fade_en,
  input  logic             boundary,
  input  logic [WIDTH-1:0] timer,
  output logic             pwm_out,
  output logic             mismatch
);

  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] active;

  // Target register: last load before a boundary wins.
  always_ff @(posedge clk12MHz) begin
    if (!resetn) begin
      target <= '0;
    end else if (duty_load) begin
      target <= duty_in;
    end
  end

  // Active duty only moves at a period boundary, using the target held before this edge.
  always_ff @(posedge clk12MHz) begin
    if (!resetn) begin
      active <= '0;
    end else if (boundary) begin
      if (fade_en) begin
        active <= WIDTH'(fade_next(duty_t'(active), duty_t'(target), duty_t'(STEP)));
      end else begin
        active <= target;
      end
    end
  end

  // Registered compare drives the pin.
  always_ff @(posedge clk12MHz) begin
    if (!resetn) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= (timer < active);
    end
  end

  assign mismatch = (active != target);

endmodule

// File: rtl/pwm_multi_channel.sv
// rtl/pwm_multi_channel.sv - N-channel PWM with shared prescaled period counter
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter int STEP     = 1
) (
  input  logic                      clk12MHz,
  input  logic                      resetn,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic                      duty_load,
  input  logic                      fade_en,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start,
  output logic                      busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] TIMER_MAX = WIDTH'(max_duty(WIDTH));

  logic [PW-1:0]       presc;
  logic [WIDTH-1:0]    timer;
  logic                tick;
  logic                boundary;
  logic [CHANNELS-1:0] mismatch;

  assign tick     = (presc == PW'(PRESCALE - 1));
  assign boundary = tick && (timer == TIMER_MAX);

  // Prescaler: one tick every PRESCALE clocks.
  always_ff @(posedge clk12MHz) begin
    if (!resetn) begin
      presc <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  // Period timer wraps naturally; period_start marks the first cycle at zero.
  always_ff @(posedge clk12MHz) begin
    if (!resetn) begin
      timer        <= '0;
      period_start <= 1'b0;
    end else begin
      if (tick) begin
        timer <= timer + WIDTH'(1);
      end
      period_start <= boundary;
    end
  end

  // busy is high while any channel is still away from its target.
  always_ff @(posedge clk12MHz) begin
    if (!resetn) begin
      busy <= 1'b0;
    end else begin
      busy <= |mismatch;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
    ) u_ch (
      .clk12MHz  (clk12MHz),
      .resetn    (resetn),
      .duty_in   (duty_in[i*WIDTH +: WIDTH]),
      .duty_load (duty_load),
      .fade_en   (fade_en),
      .boundary  (boundary),
      .timer     (timer),
      .pwm_out   (pwm_out[i]),
      .mismatch  (mismatch[i])
    );
  end

endmodule
